// File: rtl/alu_pkg.sv
// alu_pkg: shared operation/state enums and wait counter width for the ALU driver
package alu_pkg;
  typedef enum logic [1:0] {ADD = 2'd0, SUB = 2'd1, AND = 2'd2, OR = 2'd3} alu_op_e;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;
  localparam int CNT_W = 3;
endpackage

// File: rtl/alu_driver_if.sv
// alu_driver_if: command, ALU and response signals of the ALU driver
interface alu_driver_if #(parameter int N = 4);
  logic cmd_valid;
  logic cmd_ready;
  logic [1:0] cmd_op;
  logic [N-1:0] cmd_a;
  logic [N-1:0] cmd_b;
  logic [N-1:0] alu_operand1;
  logic [N-1:0] alu_operand2;
  logic [1:0] alu_operation;
  logic [N:0] alu_result;
  logic rsp_valid;
  logic rsp_ready;
  logic [N:0] rsp_result;
  logic rsp_mismatch;
  logic [7:0] pass_count;
  logic [7:0] fail_count;
  modport slave (
    input cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, rsp_ready,
    output cmd_ready, alu_operand1, alu_operand2, alu_operation,
    output rsp_valid, rsp_result, rsp_mismatch, pass_count, fail_count
  );
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, rsp_ready,
    input cmd_ready, alu_operand1, alu_operand2, alu_operation,
    input rsp_valid, rsp_result, rsp_mismatch, pass_count, fail_count
  );
endinterface

// File: rtl/alu_ref_model.sv
// alu_ref_model: combinational expected result of an ALU operation
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   op,
  output logic [N:0]   y
);
  always_comb begin
    y = alu_op_e'(op) == ADD ? {1'b0, a} + {1'b0, b} :
        alu_op_e'(op) == SUB ? {1'b0, a} - {1'b0, b} :
        alu_op_e'(op) == AND ? {1'b0, a & b} : {1'b0, a | b};
  end
endmodule

// File: rtl/alu_driver.sv
// alu_driver: issues commands to an external ALU, checks its result after LAT clocks, reports responses
module alu_driver
  import alu_pkg::*;
#(
  parameter int N   = 4,
  parameter int LAT = 1
) (
  input logic         clk,
  input logic         reset,
  alu_driver_if.slave bus
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0] a_q, a_d, b_q, b_d;
  logic [1:0] op_q, op_d;
  logic [N:0] res_q, res_d, expected;
  logic mis_q, mis_d;
  logic [7:0] pass_q, pass_d, fail_q, fail_d;
  alu_ref_model #(.N(N)) u_ref (.a(a_q), .b(b_q), .op(op_q), .y(expected));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    mis_d   = mis_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        a_d     = bus.cmd_a;
        b_d     = bus.cmd_b;
        op_d    = bus.cmd_op;
        cnt_d   = CNT_W'(LAT);
        state_d = WAIT;
      end
      WAIT: if (cnt_q == '0) begin
        res_d   = bus.alu_result;
        mis_d   = bus.alu_result != expected;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
      RESP: if (bus.rsp_ready) begin
        pass_d  = (!mis_q && pass_q != 8'hff) ? pass_q + 8'd1 : pass_q;
        fail_d  = (mis_q && fail_q != 8'hff) ? fail_q + 8'd1 : fail_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      mis_q   <= 1'b0;
      pass_q  <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      mis_q   <= mis_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end
  assign bus.cmd_ready     = state_q == IDLE;
  assign bus.rsp_valid     = state_q == RESP;
  assign bus.alu_operand1  = a_q;
  assign bus.alu_operand2  = b_q;
  assign bus.alu_operation = op_q;
  assign bus.rsp_result    = res_q;
  assign bus.rsp_mismatch  = mis_q;
  assign bus.pass_count    = pass_q;
  assign bus.fail_count    = fail_q;
endmodule

// File: tb/tb_alu_driver.sv
// tb_alu_driver: directed checks of alu_driver with LAT=1, plus LAT=0 and LAT=7 sampling builds
module tb_alu_driver;
  logic clk, reset, fault;
  int cyc, n_cmp, n_err;
  alu_driver_if #(.N(4)) bus ();
  alu_driver_if #(.N(4)) bus0 ();
  alu_driver_if #(.N(4)) bus7 ();
  alu_driver #(.N(4), .LAT(1)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  alu_driver #(.N(4), .LAT(0)) u_lat0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  alu_driver #(.N(4), .LAT(7)) u_lat7 (.clk(clk), .reset(reset), .bus(bus7.slave));
  function automatic logic [4:0] alu(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    return op == 2'd0 ? {1'b0, a} + {1'b0, b} : op == 2'd1 ? {1'b0, a} - {1'b0, b} :
           op == 2'd2 ? {1'b0, a & b} : {1'b0, a | b};
  endfunction
  assign bus.alu_result = alu(bus.alu_operation, bus.alu_operand1, bus.alu_operand2)
                          + {4'd0, fault && bus.alu_operation == 2'd0};
  assign bus0.alu_result = 5'(cyc);
  assign bus7.alu_result = 5'(cyc);
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    bus.cmd_op = op;
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_valid = 1;
    @(negedge clk);
    bus.cmd_valid = 0;
  endtask
  task automatic wait_rsp(output bit got);
    got = 0;
    for (int i = 0; i < 20 && !got; i++)
      if (bus.rsp_valid === 1'b1) got = 1;
      else @(negedge clk);
  endtask
  task automatic handshake;
    bus.rsp_ready = 1;
    @(negedge clk);
    bus.rsp_ready = 0;
  endtask
  task automatic test_reset;
    reset = 1;
    bus.cmd_valid = 1;
    bus.rsp_ready = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    bus.cmd_valid = 0;
    bus.rsp_ready = 0;
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready got %b want 1", bus.cmd_ready); end
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    n_cmp++; if ({bus.alu_operand1, bus.alu_operand2, bus.alu_operation} !== 10'd0) begin n_err++; $display("FAIL reset_alu_outputs got %h want 0", {bus.alu_operand1, bus.alu_operand2, bus.alu_operation}); end
    n_cmp++; if ({bus.rsp_result, bus.rsp_mismatch, bus.pass_count, bus.fail_count} !== 22'd0) begin n_err++; $display("FAIL reset_rsp_counts got %h want 0", {bus.rsp_result, bus.rsp_mismatch, bus.pass_count, bus.fail_count}); end
  endtask
  task automatic test_add_timing;
    bit got;
    issue(2'd0, 4'd7, 4'd10);
    n_cmp++; if ({bus.alu_operand1, bus.alu_operand2, bus.alu_operation} !== {4'd7, 4'd10, 2'd0}) begin n_err++; $display("FAIL add_alu_regs got %h want %h", {bus.alu_operand1, bus.alu_operand2, bus.alu_operation}, {4'd7, 4'd10, 2'd0}); end
    n_cmp++; if ({bus.cmd_ready, bus.rsp_valid} !== 2'b00) begin n_err++; $display("FAIL add_e0_flags got %b want 00", {bus.cmd_ready, bus.rsp_valid}); end
    @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL add_e1_rsp_valid got %b want 0", bus.rsp_valid); end
    @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL add_e2_rsp_valid got %b want 1", bus.rsp_valid); end
    n_cmp++; if ({bus.rsp_result, bus.rsp_mismatch} !== {5'd17, 1'b0}) begin n_err++; $display("FAIL add_result got %0d/%b want 17/0", bus.rsp_result, bus.rsp_mismatch); end
    handshake();
    n_cmp++; if ({bus.pass_count, bus.fail_count, bus.cmd_ready, bus.rsp_valid} !== {8'd1, 8'd0, 2'b10}) begin n_err++; $display("FAIL add_handshake got pass=%0d fail=%0d rdy=%b vld=%b want 1 0 1 0", bus.pass_count, bus.fail_count, bus.cmd_ready, bus.rsp_valid); end
    got = 1;
  endtask
  task automatic test_ops;
    bit got;
    logic [1:0] ops [3] = '{2'd1, 2'd2, 2'd3};
    logic [3:0] as [3] = '{4'd0, 4'd12, 4'd11};
    logic [3:0] bs [3] = '{4'd2, 4'd10, 4'd2};
    logic [4:0] want [3] = '{5'h1e, 5'd8, 5'd11};
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_rsp(got);
      n_cmp++; if (!got) begin n_err++; $display("FAIL ops_timeout op=%0d got no rsp_valid want rsp_valid", ops[i]); end
      n_cmp++; if ({bus.rsp_result, bus.rsp_mismatch} !== {want[i], 1'b0}) begin n_err++; $display("FAIL ops_result op=%0d got %h/%b want %h/0", ops[i], bus.rsp_result, bus.rsp_mismatch, want[i]); end
      handshake();
      n_cmp++; if (bus.pass_count !== 8'(2 + i)) begin n_err++; $display("FAIL ops_pass_count got %0d want %0d", bus.pass_count, 2 + i); end
    end
  endtask
  task automatic test_faulty;
    bit got;
    fault = 1;
    issue(2'd0, 4'd1, 4'd1);
    wait_rsp(got);
    n_cmp++; if ({got, bus.rsp_result, bus.rsp_mismatch} !== {1'b1, 5'd3, 1'b1}) begin n_err++; $display("FAIL faulty_result got v=%b %0d/%b want 1 3/1", got, bus.rsp_result, bus.rsp_mismatch); end
    handshake();
    fault = 0;
    n_cmp++; if ({bus.pass_count, bus.fail_count} !== {8'd4, 8'd1}) begin n_err++; $display("FAIL faulty_counts got pass=%0d fail=%0d want 4 1", bus.pass_count, bus.fail_count); end
  endtask
  task automatic test_backpressure;
    bit got;
    bit bad = 0;
    issue(2'd0, 4'd3, 4'd4);
    wait_rsp(got);
    bus.cmd_a = 4'd15;
    bus.cmd_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if ({bus.rsp_valid, bus.rsp_result, bus.rsp_mismatch, bus.cmd_ready, bus.pass_count, bus.fail_count, bus.alu_operand1} !== {1'b1, 5'd7, 1'b0, 1'b0, 8'd4, 8'd1, 4'd3}) bad = 1;
    end
    bus.cmd_valid = 0;
    n_cmp++; if ({got, bad} !== 2'b10) begin n_err++; $display("FAIL backpressure_hold got valid=%b unstable=%b want 1 0", got, bad); end
    handshake();
    n_cmp++; if (bus.pass_count !== 8'd5) begin n_err++; $display("FAIL backpressure_pass got %0d want 5", bus.pass_count); end
  endtask
  task automatic test_back_to_back;
    bit got;
    issue(2'd3, 4'd5, 4'd3);
    wait_rsp(got);
    bus.rsp_ready = 1;
    bus.cmd_op = 2'd2;
    bus.cmd_a = 4'd9;
    bus.cmd_b = 4'd6;
    bus.cmd_valid = 1;
    @(negedge clk);
    bus.rsp_ready = 0;
    n_cmp++; if ({bus.cmd_ready, bus.alu_operand1} !== {1'b1, 4'd5}) begin n_err++; $display("FAIL b2b_no_same_cycle got rdy=%b op1=%0d want 1 5", bus.cmd_ready, bus.alu_operand1); end
    @(negedge clk);
    bus.cmd_valid = 0;
    n_cmp++; if ({bus.cmd_ready, bus.alu_operand1, bus.alu_operation} !== {1'b0, 4'd9, 2'd2}) begin n_err++; $display("FAIL b2b_next_accept got rdy=%b op1=%0d op=%0d want 0 9 2", bus.cmd_ready, bus.alu_operand1, bus.alu_operation); end
    wait_rsp(got);
    n_cmp++; if ({got, bus.rsp_result, bus.rsp_mismatch} !== {1'b1, 5'd0, 1'b0}) begin n_err++; $display("FAIL b2b_result got v=%b %0d/%b want 1 0/0", got, bus.rsp_result, bus.rsp_mismatch); end
    handshake();
    n_cmp++; if (bus.pass_count !== 8'd7) begin n_err++; $display("FAIL b2b_pass got %0d want 7", bus.pass_count); end
  endtask
  task automatic test_reset_midflight;
    bit seen = 0;
    issue(2'd0, 4'd2, 4'd2);
    reset = 1;
    bus.rsp_ready = 1;
    @(negedge clk);
    reset = 0;
    bus.rsp_ready = 0;
    n_cmp++; if ({bus.cmd_ready, bus.rsp_valid, bus.pass_count, bus.fail_count, bus.alu_operand1} !== {2'b10, 16'd0, 4'd0}) begin n_err++; $display("FAIL midreset_state got rdy=%b vld=%b pass=%0d fail=%0d op1=%0d want 1 0 0 0 0", bus.cmd_ready, bus.rsp_valid, bus.pass_count, bus.fail_count, bus.alu_operand1); end
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) seen = 1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midreset_no_rsp got rsp_valid=1 want 0"); end
  endtask
  task automatic test_saturation;
    bit got;
    bit lost = 0;
    for (int i = 0; i < 256; i++) begin
      issue(2'd0, 4'd1, 4'd0);
      wait_rsp(got);
      if (!got) lost = 1;
      handshake();
      if (i == 254) begin
        n_cmp++; if (bus.pass_count !== 8'd255) begin n_err++; $display("FAIL sat_reach got %0d want 255", bus.pass_count); end
      end
    end
    n_cmp++; if ({lost, bus.pass_count, bus.fail_count} !== {1'b0, 8'd255, 8'd0}) begin n_err++; $display("FAIL sat_hold got lost=%b pass=%0d fail=%0d want 0 255 0", lost, bus.pass_count, bus.fail_count); end
  endtask
  task automatic test_lat_extremes;
    int c0, k0, k7;
    logic [4:0] r0, r7;
    k0 = -1;
    k7 = -1;
    @(negedge clk);
    c0 = cyc;
    bus0.cmd_valid = 1;
    bus7.cmd_valid = 1;
    @(negedge clk);
    bus0.cmd_valid = 0;
    bus7.cmd_valid = 0;
    for (int j = 0; j < 12; j++) begin
      if (k0 < 0 && bus0.rsp_valid === 1'b1) begin k0 = j; r0 = bus0.rsp_result; end
      if (k7 < 0 && bus7.rsp_valid === 1'b1) begin k7 = j; r7 = bus7.rsp_result; end
      @(negedge clk);
    end
    n_cmp++; if (k0 !== 1 || r0 !== 5'(c0 + 1)) begin n_err++; $display("FAIL lat0_sample got edge=%0d val=%0d want 1 %0d", k0, r0, 5'(c0 + 1)); end
    n_cmp++; if (k7 !== 8 || r7 !== 5'(c0 + 8)) begin n_err++; $display("FAIL lat7_sample got edge=%0d val=%0d want 8 %0d", k7, r7, 5'(c0 + 8)); end
    bus0.rsp_ready = 1;
    bus7.rsp_ready = 1;
    @(negedge clk);
  endtask
  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    fault = 0;
    reset = 1;
    {bus.cmd_valid, bus.rsp_ready, bus.cmd_op, bus.cmd_a, bus.cmd_b} = '0;
    {bus0.cmd_valid, bus0.rsp_ready, bus0.cmd_op, bus0.cmd_a, bus0.cmd_b} = '0;
    {bus7.cmd_valid, bus7.rsp_ready, bus7.cmd_op, bus7.cmd_a, bus7.cmd_b} = '0;
    test_reset();
    test_add_timing();
    test_ops();
    test_faulty();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    test_saturation();
    test_lat_extremes();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_driver.md
ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 The block SHALL have parameter N, default 4, operand width in bits.
REQ-002 The block SHALL have parameter LAT, default 1, ALU result latency in clocks; legal range 0..7.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 cmd_valid  input  1  command present.
REQ-007 cmd_ready  output  1  driver can accept a command.
REQ-008 cmd_op  input  2  operation code.
REQ-009 cmd_a  input  N  first operand.
REQ-010 cmd_b  input  N  second operand.
REQ-011 alu_operand1  output  N  operand to ALU.
REQ-012 alu_operand2  output  N  operand to ALU.
REQ-013 alu_operation  output  2  operation to ALU.
REQ-014 alu_result  input  N+1  result from ALU.
REQ-015 rsp_valid  output  1  response present.
REQ-016 rsp_ready  input  1  consumer accepts response.
REQ-017 rsp_result  output  N+1  captured ALU result.
REQ-018 rsp_mismatch  output  1  captured result differs from expected.
REQ-019 pass_count  output  8  matched responses delivered, saturating.
REQ-020 fail_count  output  8  mismatched responses delivered, saturating.

Function
REQ-021 The block SHALL implement FSM states IDLE, WAIT, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-022 On cmd_valid && cmd_ready at edge E0, the block SHALL register cmd_a/cmd_b/cmd_op onto alu_operand1/alu_operand2/alu_operation, compute the expected result, load wait counter with LAT, and enter WAIT.
REQ-023 alu_* outputs SHALL hold their last accepted values until the next accepted command.
REQ-024 The block SHALL sample alu_result at edge E0+LAT+1 into rsp_result, set rsp_mismatch = (alu_result != expected), and enter RESP; rsp_valid is 1 from that edge.
REQ-025 Expected result: op 0 ADD = zero-extended a + b; op 1 SUB = ({1'b0,a} - {1'b0,b}) mod 2^(N+1); op 2 AND = zero-extended a & b; op 3 OR = zero-extended a | b.
REQ-026 In RESP, rsp_valid, rsp_result and rsp_mismatch SHALL remain stable until rsp_ready is 1; on that edge the FSM SHALL return to IDLE.
REQ-027 pass_count or fail_count SHALL increment on the rsp handshake edge only, per rsp_mismatch, saturating at 255.
REQ-028 A command SHALL NOT be accepted in the same cycle a response handshakes; earliest next acceptance is the following cycle (throughput one command per LAT+3 cycles minimum).
REQ-029 cmd_valid while not in IDLE SHALL be ignored with no state change.
REQ-030 alu_result SHALL be ignored in all cycles other than the sampling edge.

Reset
REQ-031 On reset the FSM SHALL enter IDLE; all outputs except cmd_ready SHALL be 0, cmd_ready SHALL be 1 in the first cycle after reset.
REQ-032 Reset during WAIT or RESP SHALL abandon the command; no response SHALL be delivered and counters SHALL clear.
REQ-033 reset SHALL take priority over cmd_valid and rsp_ready in the same cycle.

Structure
REQ-034 A shared package alu_pkg SHALL hold the operation enum (ADD=0, SUB=1, AND=2, OR=3) and the state enum.
REQ-035 Expected-result computation SHALL be a combinational sub-module alu_ref_model, parameterised by N.
REQ-036 Wait counter width SHALL be 3 bits.

Verification (N=4, LAT=1 unless stated)
REQ-037 ADD a=7 b=10 -> rsp_result=17, rsp_mismatch=0, rsp_valid rises at E0+2, pass_count=1.
REQ-038 SUB a=0 b=2 -> rsp_result=5'h1E; AND a=12 b=10 -> 8; OR a=11 b=2 -> 11; all mismatch=0.
REQ-039 Faulty ALU model returning result+1 on ADD 1+1 -> rsp_result=3, rsp_mismatch=1, fail_count=1.
REQ-040 rsp_ready held low 5 cycles -> rsp_valid/rsp_result stable, cmd_ready=0, counters unchanged until handshake.
REQ-041 Reset asserted one cycle after acceptance -> no rsp_valid, counters 0, cmd_ready=1 after reset.
REQ-042 LAT=0 and LAT=7 builds -> sampling at E0+1 and E0+8 respectively.
